// File: rtl/dag_unit.sv
// rtl/dag_unit.sv - data address generator with four circular I/M/L/B sets and ureg access
// Optional feature macro: DAG_BITREV_EN (bit-reversed post-modify addressing).
module dag_unit #(
  parameter int DMA_SIZE = 16,
  parameter int DMD_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps_dg_en,
  input  logic [1:0]          ps_dg_i,
  input  logic [1:0]          ps_dg_m,
  input  logic                ps_dg_pre,
  input  logic                ps_dg_brev,
  input  logic                ps_dg_wrt_en,
  input  logic [3:0]          ps_dg_wrt_add,
  input  logic [3:0]          ps_dg_rd_add,
  input  logic [DMD_SIZE-1:0] bc_dt,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMD_SIZE-1:0] dg_bc_dt
);

  typedef logic [DMA_SIZE-1:0] addr_t;

  addr_t i_q [4];
  addr_t i_d [4];
  addr_t m_q [4];
  addr_t m_d [4];
  addr_t l_q [4];
  addr_t l_d [4];
  addr_t b_q [4];
  addr_t b_d [4];

  addr_t mod_sum;
  addr_t circ_sum;
  addr_t next_i;
  addr_t wr_data;
  addr_t rd_val;
  logic  rd_sign;
  logic  use_brev;
  logic  post_upd;

  // Wrap is computed against the window end B+L taken modulo 2^DMA_SIZE.
  function automatic addr_t circ(input addr_t x, input addr_t b, input addr_t l);
    addr_t top;
    top = b + l;
    if (l == '0)      return x;
    else if (x >= top) return x - l;
    else if (x < b)    return x + l;
    else               return x;
  endfunction

`ifdef DAG_BITREV_EN
  function automatic addr_t bit_rev(input addr_t x);
    addr_t r;
    for (int k = 0; k < DMA_SIZE; k++) r[k] = x[DMA_SIZE-1-k];
    return r;
  endfunction
`endif

  always_comb begin
    mod_sum  = i_q[ps_dg_i] + m_q[ps_dg_m];
    circ_sum = circ(mod_sum, b_q[ps_dg_i], l_q[ps_dg_i]);
    use_brev = 1'b0;
`ifdef DAG_BITREV_EN
    use_brev = ps_dg_en & ~ps_dg_pre & ps_dg_brev;
`endif
    post_upd = ps_dg_en & ~ps_dg_pre;
    next_i   = use_brev ? mod_sum : circ_sum;

    dg_dm_add = '0;
    if (ps_dg_en) begin
      if (ps_dg_pre) dg_dm_add = circ_sum;
`ifdef DAG_BITREV_EN
      else if (use_brev) dg_dm_add = bit_rev(i_q[ps_dg_i]);
`endif
      else dg_dm_add = i_q[ps_dg_i];
    end
  end

  always_comb begin
    wr_data = bc_dt[DMA_SIZE-1:0];
    i_d = i_q;
    m_d = m_q;
    l_d = l_q;
    b_d = b_q;
    if (post_upd) i_d[ps_dg_i] = next_i;
    // Ureg write is applied last so it overrides a same-cycle post-modify.
    if (ps_dg_wrt_en) begin
      case (ps_dg_wrt_add[3:2])
        2'b00: i_d[ps_dg_wrt_add[1:0]] = wr_data;
        2'b01: m_d[ps_dg_wrt_add[1:0]] = wr_data;
        2'b10: l_d[ps_dg_wrt_add[1:0]] = wr_data;
        default: begin
          b_d[ps_dg_wrt_add[1:0]] = wr_data;
          i_d[ps_dg_wrt_add[1:0]] = wr_data;
        end
      endcase
    end
  end

  always_comb begin
    case (ps_dg_rd_add[3:2])
      2'b00:   rd_val = i_q[ps_dg_rd_add[1:0]];
      2'b01:   rd_val = m_q[ps_dg_rd_add[1:0]];
      2'b10:   rd_val = l_q[ps_dg_rd_add[1:0]];
      default: rd_val = b_q[ps_dg_rd_add[1:0]];
    endcase
    rd_sign  = (ps_dg_rd_add[3:2] == 2'b01) & rd_val[DMA_SIZE-1];
    dg_bc_dt = {DMD_SIZE{rd_sign}};
    dg_bc_dt[DMA_SIZE-1:0] = rd_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      i_q <= i_d;
      m_q <= m_d;
      l_q <= l_d;
      b_q <= b_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ps_dg_brev, bc_dt};

endmodule

// File: doc/dag_unit.md
# dag_unit

Data address generator that sits directly upstream of the data-memory port: it owns four circular-buffer register sets (I, M, L, B) and drives `dg_dm_add` to memory in the same cycle the sequencer asserts `ps_dm_cslt`. It supports pre-modify and post-modify addressing with circular wrap, and universal-register reads and writes over the `bc_dt` bus. The sequencer drives control; the bus connect supplies and consumes register data.

## Interface
- `DMA_SIZE`, 16: data-memory address width; width of every I/L/B/M register.
- `DMD_SIZE`, 16: data bus width.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ps_dg_en` input 1: DM address request this cycle.
- `ps_dg_i` input 2: I/L/B set used for the request.
- `ps_dg_m` input 2: M register used for the request.
- `ps_dg_pre` input 1: 1 = pre-modify, 0 = post-modify.
- `ps_dg_brev` input 1: bit-reverse request (see Configuration).
- `ps_dg_wrt_en` input 1: ureg write strobe.
- `ps_dg_wrt_add` input 4: ureg write select; [3:2] type (00 I, 01 M, 10 L, 11 B), [1:0] index.
- `ps_dg_rd_add` input 4: ureg read select, same encoding.
- `bc_dt` input DMD_SIZE: ureg write data.
- `dg_dm_add` output DMA_SIZE: data-memory address.
- `dg_bc_dt` output DMD_SIZE: ureg read data.

## Operation
- Register file: I0-3, M0-3, L0-3, B0-3, all DMA_SIZE wide; all reset to 0.
- Ureg write: when `ps_dg_wrt_en`=1, the selected register loads `bc_dt[DMA_SIZE-1:0]`. Writing Bn also loads In with the same value. Writing Ln does not change In.
- Ureg read: `dg_bc_dt` combinationally shows the register selected by `ps_dg_rd_add`. I/L/B are zero-extended to DMD_SIZE; M is sign-extended.
- M values are two's-complement signed. All sums are taken modulo 2^DMA_SIZE.
- Pre-modify (`ps_dg_pre`=1): `dg_dm_add` = circ(I+M). I is unchanged.
- Post-modify (`ps_dg_pre`=0): `dg_dm_add` = I. At the clock edge, I is updated to circ(I+M).
- circ(x) with L≠0:
  - if x ≥ B+L, result is x−L;
  - if x < B, result is x+L;
  - otherwise x.
  - Comparisons are unsigned. Valid only when |M| ≤ L and I is in [B, B+L−1]. Outside that range the result is x−L / x+L, not clamped.
- circ(x) with L=0: linear addressing, result is x.
- Idle (`ps_dg_en`=0): `dg_dm_add` = 0 and no I update.
- Simultaneous ureg write and post-modify on the same In: the ureg write wins. A ureg write to Mn/Ln/Bn in the same cycle has no effect on that cycle's address; the address uses the pre-edge values.

## Timing
- `dg_dm_add` is combinational from the register state and the request inputs. It is valid in the cycle `ps_dg_en` is high, i.e. when memory samples it on the next edge alongside `ps_dm_cslt`. Zero-cycle latency.
- The post-modify I update is visible on the following cycle. Back-to-back post-modify requests on the same I therefore chain correctly every cycle.
- Ureg writes become visible on `dg_bc_dt` and in address computation one cycle after the strobe.
- Reset (asynchronous, any time, including mid-sequence):
  - all registers are 0 immediately;
  - `dg_dm_add` = 0 (or, while `ps_dg_en` is held high, the address computed from all-zero registers);
  - `dg_bc_dt` = 0.
- No I update occurs on any edge while `rst`=0.

## Configuration
- `DAG_BITREV_EN` defined:
  - with `ps_dg_en`=1, `ps_dg_pre`=0 and `ps_dg_brev`=1, `dg_dm_add` = bit-reverse of I over DMA_SIZE bits;
  - I still post-updates as linear I+M, with no circular wrap.
- `DAG_BITREV_EN` undefined:
  - `ps_dg_brev` is ignored; the port remains for a stable interface;
  - all requests use normal addressing.

## Test plan
- Reset: assert `rst`=0 mid-sequence with I0=0x0123 -> I0 reads 0 immediately, `dg_bc_dt`=0, `dg_dm_add`=0 while idle.
- Circular post-modify: B0=0x0100, L0=4, M0=1, five post-modify requests on I0 -> addresses 0x100, 0x101, 0x102, 0x103, 0x100. With M0=0xFFFF (−1) starting at I0=0x100 -> address 0x100, then I0=0x103.
- Pre-modify: I1=0x0020, M1=3, L1=0 -> `dg_dm_add`=0x0023, I1 stays 0x0020. M1=0xFFFE, I1=0x0000 -> address 0xFFFE.
- Collision: ureg write I2=0x0050 in the same cycle as a post-modify on I2 (I2=0x10, M=1) -> address 0x10, then I2=0x0050. Separately, writing B3=0x0200 -> I3 reads 0x0200.
- Ureg readback: M0=0x8001 with DMD_SIZE=16 -> `dg_bc_dt`=0x8001. Rebuild with DMA_SIZE=8, DMD_SIZE=16, write M0 with `bc_dt`=0x0081 -> M0=0x81, `dg_bc_dt`=0xFF81 (sign-extended).
- Bit-reverse: with `DAG_BITREV_EN`, I0=0x0001, M0=0x0100, `ps_dg_brev`=1 -> address 0x8000, then I0=0x0101. Without the macro -> address 0x0001.
